// File: rtl/compare_seq.sv
// Sequential magnitude comparator: scans the operands CHUNK bits per cycle,
// MSB chunk first, and stops early at the first differing chunk.
module compare_seq #(
  parameter  int WIDTH = 8,
  parameter  int CHUNK = 2,
  localparam int NCH   = WIDTH / CHUNK,
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CW    = $clog2(NCH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AgtB,
  output logic             AeqB,
  output logic             AltB,
  output logic [CW-1:0]    cycles
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] ca, cb;
  logic             fin;

  assign busy = (state == BUSY);

  always_comb begin
    ca        = a_q[int'(idx)*CHUNK +: CHUNK];
    cb        = b_q[int'(idx)*CHUNK +: CHUNK];
    fin       = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        fin = (ca != cb) || (idx == '0);
        if (fin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flipping the sign bit maps two's-complement order onto unsigned order
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      AgtB   <= 1'b0;
      AeqB   <= 1'b0;
      AltB   <= 1'b0;
      cycles <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE && start) begin
        a_q <= {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
        b_q <= {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
        idx <= IW'(NCH - 1);
        cnt <= CW'(1);
      end else if (fin) begin
        done   <= 1'b1;
        AgtB   <= (ca > cb);
        AeqB   <= (ca == cb);
        AltB   <= (ca < cb);
        cycles <= cnt;
      end else if (state == BUSY) begin
        idx <= idx - 1'b1;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_compare_seq.sv
// Directed + random bench for compare_seq with a result scoreboard.
module tb_compare_seq;

  logic       clk = 1'b0;
  logic       rst, start, signed_mode;
  logic [7:0] A, B;
  logic       busy, done, AgtB, AeqB, AltB;
  logic [2:0] cycles;

  typedef struct {
    logic       gt;
    logic       eq;
    logic       lt;
    logic [2:0] k;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  compare_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .signed_mode(signed_mode), .A(A), .B(B),
    .busy(busy), .done(done), .AgtB(AgtB),
    .AeqB(AeqB), .AltB(AltB), .cycles(cycles)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, b, input logic sm);
    exp_t e;
    bit   found;
    int   sa, sbv;
    sa  = sm ? int'($signed(a)) : int'(a);
    sbv = sm ? int'($signed(b)) : int'(b);
    e.gt = (sa > sbv);
    e.eq = (sa == sbv);
    e.lt = (sa < sbv);
    e.k  = 3'd4;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && a[2*i +: 2] != b[2*i +: 2]) begin
        e.k   = 3'(4 - i);
        found = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Called #1 after the start edge; waits for done and checks the result.
  task automatic wait_done(input string tag, input bit tamper);
    int   lat   = 0;
    int   bcnt  = 0;
    bit   seen  = 1'b0;
    exp_t e;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (busy) bcnt++;
      if (tamper && n == 0) begin
        A = 8'hFF;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (tamper && n == 0) start = 1'b0;
      lat++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_gt"}, int'(AgtB), int'(e.gt));
      chk({tag, "_eq"}, int'(AeqB), int'(e.eq));
      chk({tag, "_lt"}, int'(AltB), int'(e.lt));
      chk({tag, "_cycles"}, int'(cycles), int'(e.k));
      chk({tag, "_latency"}, lat, int'(e.k));
      chk({tag, "_busy_cycles"}, bcnt, int'(e.k));
      chk({tag, "_busy_at_done"}, int'(busy), 0);
    end
  endtask

  task automatic run(input logic [7:0] a, b, input logic sm,
                     input string tag, input bit tamper);
    sb.push_back(model(a, b, sm));
    A = a;
    B = b;
    signed_mode = sm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_start"}, int'(busy), 1);
    wait_done(tag, tamper);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({AgtB, AeqB, AltB}), 0);
    chk("rst_cycles", int'(cycles), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(8'hA5, 8'h3C, 1'b0, "gt_unsigned", 1'b0);
    run(8'h5A, 8'h5A, 1'b0, "eq_full", 1'b0);
    run(8'hFF, 8'h01, 1'b1, "signed_lt", 1'b0);
    run(8'hFF, 8'h01, 1'b0, "unsigned_gt", 1'b0);
    run(8'h12, 8'h13, 1'b0, "tamper_lt", 1'b1);
    chk("tamper_hold_lt", int'(AltB), 1);

    // Reset in the 2nd BUSY cycle aborts without a done pulse
    A = 8'h00;
    B = 8'h00;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_pre", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_flags", int'({AgtB, AeqB, AltB}), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cycles", int'(cycles), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk);
    #1;
    chk("abort_done_after", int'(done), 0);

    // Back-to-back with start held across completion
    sb.push_back(model(8'h80, 8'h40, 1'b0));
    A = 8'h80;
    B = 8'h40;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("b2b_first", 1'b0);
    sb.push_back(model(8'h01, 8'h02, 1'b0));
    A = 8'h01;
    B = 8'h02;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_no_gap_busy", int'(busy), 1);
    chk("b2b_no_gap_done", int'(done), 0);
    chk("b2b_hold_gt", int'(AgtB), 1);
    wait_done("b2b_second", 1'b0);

    run(8'h7F, 8'h80, 1'b1, "signed_pos_neg", 1'b0);
    run(8'h80, 8'h80, 1'b1, "signed_eq_min", 1'b0);
    run(8'hFE, 8'hFF, 1'b1, "signed_neg_lt", 1'b0);
    for (int r = 0; r < 10; r++) begin
      run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), "rand", 1'b0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/compare_seq.md
COMPARE_SEQ -- requirements
Module: compare_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand width in bits; WIDTH >= 2.
REQ-002 The module SHALL have parameter CHUNK, default 2, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit, requests a comparison of A and B.
REQ-006 The module SHALL have port signed_mode, input, 1 bit: 1 = two's-complement compare, 0 = unsigned.
REQ-007 The module SHALL have ports A and B, input, WIDTH bits each, the operands.
REQ-008 The module SHALL have port busy, output, 1 bit, high while a comparison is in progress.
REQ-009 The module SHALL have port done, output, 1 bit, a one-cycle pulse when the result becomes valid.
REQ-010 The module SHALL have ports AgtB, AeqB and AltB, output, 1 bit each, registered result flags.
REQ-011 The module SHALL have port cycles, output, $clog2(NCH)+1 bits, the number of chunks examined by the last comparison.

Function
REQ-012 The module SHALL implement FSM states IDLE and BUSY.
REQ-013 IDLE -> BUSY SHALL occur on an edge with start=1. At that edge A, B and signed_mode SHALL be captured, the chunk index set to NCH-1 (MSB chunk) and busy set to 1.
REQ-014 In signed mode the capture SHALL invert bit WIDTH-1 of both captured operands, so that an unsigned chunk compare yields the signed order.
REQ-015 Each BUSY cycle SHALL compare exactly one captured chunk pair, MSB chunk first, as an unsigned CHUNK-bit compare.
REQ-016 If the chunks differ, the next edge SHALL:
- set AgtB/AltB per the chunk order, with the other two flags 0;
- set done=1, busy=0 and state IDLE (early termination).
REQ-017 If the chunks are equal and the index is 0, the next edge SHALL set AeqB=1, AgtB=AltB=0, done=1, busy=0 and state IDLE.
REQ-018 If the chunks are equal and the index is greater than 0, the index SHALL decrement and the state SHALL remain BUSY.
REQ-019 Latency: done SHALL rise k edges after the start edge, where k = number of chunks examined, 1 <= k <= NCH; cycles SHALL be loaded with k together with done.
REQ-020 After any completed comparison exactly one of AgtB/AeqB/AltB SHALL be 1; the flags and cycles SHALL hold until the next completion or reset.
REQ-021 start while BUSY SHALL be ignored; A, B and signed_mode changes while BUSY SHALL NOT affect the result.
REQ-022 start sampled in the cycle where done=1 (state already IDLE) SHALL be accepted; back-to-back comparisons SHALL incur no idle cycle.
REQ-023 done SHALL be high for exactly one cycle per completed comparison and SHALL never be high while busy=1.
REQ-024 The result flags SHALL NOT change while busy=1.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, AgtB=AeqB=AltB=0 and cycles=0, and SHALL take precedence over start.
REQ-026 rst asserted mid-BUSY SHALL abort the comparison with no done pulse; all-zero flags SHALL mean "no result yet".

Verification (WIDTH=8, CHUNK=2)
REQ-027 Unsigned, A=8'hA5, B=8'h3C, start -> done 1 edge after start, AgtB=1, cycles=1.
REQ-028 Unsigned, A=B=8'h5A -> done 4 edges after start, AeqB=1, cycles=4, busy high for 4 cycles.
REQ-029 A=8'hFF, B=8'h01 -> signed_mode=1 gives AltB=1, cycles=1; signed_mode=0 gives AgtB=1, cycles=1.
REQ-030 Unsigned, A=8'h12, B=8'h13 -> AltB=1, cycles=4; A changed to 8'hFF and start pulsed during BUSY must leave that result unchanged.
REQ-031 rst during the 2nd BUSY cycle of A=B=8'h00 -> next cycle: all flags 0, busy=0, cycles=0, no done pulse.
REQ-032 start held high across completion of A=8'h80, B=8'h40 then A=8'h01, B=8'h02 -> second comparison starts on the done edge, yielding AgtB then AltB with no gap cycle.
